// File: rtl/bus_pkg.sv
// ============================================================================
// bus_pkg : shared constants and helpers for the 4-master shared bus
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bus_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int BUS_OWNER_W   = 2;
  localparam int BUS_MASTER_CH = 4;

  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_0 = 2'd0;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_1 = 2'd1;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_2 = 2'd2;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_3 = 2'd3;

  typedef logic [BUS_OWNER_W-1:0] owner_t;

  // Out-of-range encodings fall back to master 0 so no X reaches the grants.
  function automatic logic [BUS_MASTER_CH-1:0] owner_onehot(input owner_t o);
    logic [BUS_MASTER_CH-1:0] oh;
    case (o)
      BUS_OWNER_MASTER_1: oh = 4'b0010;
      BUS_OWNER_MASTER_2: oh = 4'b0100;
      BUS_OWNER_MASTER_3: oh = 4'b1000;
      default:            oh = 4'b0001;
    endcase
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arb_rr_pick.sv
// ============================================================================
// bus_arb_rr_pick : round-robin search from owner+1 over an active-high request vector
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bus_arb_rr_pick
  import bus_pkg::*;
(
  input  logic [BUS_OWNER_W-1:0]   owner_i,
  input  logic [BUS_MASTER_CH-1:0] req_i,
  output logic [BUS_OWNER_W-1:0]   next_o,
  output logic                     found_o
);

  logic [BUS_OWNER_W-1:0] cand;

  // Scan farthest first so the nearest requester after the owner wins.
  always_comb begin
    next_o  = owner_i;
    found_o = 1'b0;
    cand    = '0;
    for (int k = BUS_MASTER_CH - 1; k >= 1; k--) begin
      cand = owner_i + BUS_OWNER_W'(k);
      if (req_i[cand]) begin
        next_o  = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter : round-robin 4-master bus arbiter with parking and tenure limit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_TENURE = 16,
  parameter int CNT_W      = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req_,
  input  logic                   m1_req_,
  input  logic                   m2_req_,
  input  logic                   m3_req_,
  output logic                   m0_grnt_,
  output logic                   m1_grnt_,
  output logic                   m2_grnt_,
  output logic                   m3_grnt_,
  output logic [BUS_OWNER_W-1:0] owner,
  output logic                   bus_busy
);

  localparam logic [CNT_W-1:0] TEN_LAST =
    (MAX_TENURE == 0) ? '0 : CNT_W'(MAX_TENURE - 1);

  logic [BUS_MASTER_CH-1:0] req_vec;
  logic [BUS_MASTER_CH-1:0] own_oh;
  logic [BUS_OWNER_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]         tenure_q, tenure_d;
  logic [BUS_OWNER_W-1:0]   pick_next;
  logic                     pick_found;
  logic                     owner_req;
  logic                     others_wait;
  logic                     handover;

  assign req_vec     = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign own_oh      = owner_onehot(owner_q);
  assign owner_req   = |(req_vec & own_oh);
  assign others_wait = |(req_vec & ~own_oh);

  bus_arb_rr_pick u_pick (
    .owner_i (owner_q),
    .req_i   (req_vec),
    .next_o  (pick_next),
    .found_o (pick_found)
  );

  always_comb begin
    owner_d  = owner_q;
    tenure_d = tenure_q;
    handover = !owner_req ||
               ((MAX_TENURE != 0) && (tenure_q == TEN_LAST) && others_wait);
    if (handover && pick_found) begin
      owner_d  = pick_next;
      tenure_d = '0;
    end else if (!owner_req || (MAX_TENURE == 0)) begin
      tenure_d = '0;
    end else if (tenure_q != TEN_LAST) begin
      tenure_d = tenure_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= BUS_OWNER_MASTER_0;
      tenure_q <= '0;
    end else begin
      owner_q  <= owner_d;
      tenure_q <= tenure_d;
    end
  end

  // Grants decode only the owner register, never the live requests.
  assign m0_grnt_ = ~own_oh[0];
  assign m1_grnt_ = ~own_oh[1];
  assign m2_grnt_ = ~own_oh[2];
  assign m3_grnt_ = ~own_oh[3];
  assign owner    = owner_q;
  assign bus_busy = owner_req;

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the 4-master shared bus.
- Sits directly upstream of the bus master multiplexer and drives the four active-low grant lines (m0_grnt_..m3_grnt_) that select which master's address, control and write data reach the slaves.
- Parks the bus on the last owner when nobody requests.
- Forces rotation after a programmable maximum tenure so one master cannot starve the others.

Parameters:
- MAX_TENURE, 16, max consecutive granted cycles while another master waits; 0 = unlimited.
- CNT_W, 5, tenure counter width; must hold MAX_TENURE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req_  in  1  master 0 bus request, active low
- m1_req_  in  1  master 1 bus request, active low
- m2_req_  in  1  master 2 bus request, active low
- m3_req_  in  1  master 3 bus request, active low
- m0_grnt_  out  1  master 0 grant, active low
- m1_grnt_  out  1  master 1 grant, active low
- m2_grnt_  out  1  master 2 grant, active low
- m3_grnt_  out  1  master 3 grant, active low
- owner  out  2  current bus owner index, BUS_OWNER_MASTER_0..3
- bus_busy  out  1  high when the current owner is asserting its request

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- State: 2-bit owner register plus a CNT_W tenure counter.
- Reset values: owner = 0, m0_grnt_ = 0, m1_grnt_..m3_grnt_ = 1, tenure = 0, bus_busy = 0.
- Grant outputs:
  - One-hot decode of the owner register (active low), so they carry no combinational path from req_.
  - Exactly one grant is low in every cycle, including idle (parking).
- Arbitration is evaluated every cycle on sampled req_. A handover is required when either:
  - the owner's req_ = 1 (released), or
  - MAX_TENURE != 0, tenure == MAX_TENURE-1, and at least one other master has req_ = 0.
- Handover search:
  - Scan owner+1, owner+2, owner+3 (mod 4, wrap 3->0); the first with req_ = 0 becomes the owner at the next clk edge.
  - If none is found, the owner is unchanged (park). On a release with no other requester, the old owner keeps the grant.
- Latency: req_ falling in cycle N on an idle bus -> grnt_ low in cycle N+1 (one edge).
  - Handover: owner releases in cycle N -> new grant in cycle N+1, old grant high in the same cycle. No overlap, no gap.
- Tenure counter:
  - Clears to 0 on every owner change.
  - Increments while the owner requests and the bus does not change owner; saturates at MAX_TENURE-1.
  - Held at 0 while the owner's req_ = 1.
  - Forced rotation only fires when another master waits; a sole requester keeps the bus indefinitely.
- Simultaneous requests: resolved purely by round-robin order from owner+1. No fixed priority.
- Owner re-requesting in the same cycle as releasing is not possible (a single req_ level); req_ = 1 for one cycle counts as a release.
- bus_busy = ~req_[owner], combinational from the registered owner.
- Reset asserted mid-transfer: immediately returns owner to master 0 and grants m0 asynchronously; the counter clears.
- No X propagation: if owner somehow decodes out of range, it is treated as master 0 (default case).

Decomposition:
- Shared package bus_pkg holds:
  - ENABLE_ = 0, DISABLE_ = 1 (active-low levels)
  - BUS_OWNER_MASTER_0..3 = 0..3
  - BUS_OWNER_W = 2
  - BUS_MASTER_CH = 4
- Sub-module bus_arb_rr_pick: combinational; inputs current owner and the 4-bit request vector, outputs next owner and a found flag. It is reused by the slave-side arbitration planned later.

Test Plan:
- Reset with all req_ = 1 -> m0_grnt_ = 0, others 1, owner = 0, bus_busy = 0; park persists for 10 cycles.
- Owner 0 idle, m2_req_ = 0 at cycle 5 -> m2_grnt_ = 0 and m0_grnt_ = 1 at cycle 6, owner = 2, bus_busy = 1.
- Owner 1 releases while m0_req_, m2_req_ and m3_req_ are all 0 -> owner = 2 next cycle. Then release order m2, m3 -> owners go 3, 0 (wrap checked).
- MAX_TENURE = 4, m1 holds its request continuously and m3 requests -> m1 keeps the grant exactly 4 cycles, then owner = 3. With m1 as sole requester it holds 50 cycles without rotation.
- Reset pulsed for one cycle, asynchronous to clk, while owner = 3 is busy -> m0_grnt_ = 0 immediately, owner = 0, tenure = 0.
- Random req_ streams, 10k cycles, with a checker: exactly one grnt_ low every cycle, and no requester waits more than 3*MAX_TENURE+3 cycles.
